// File: rtl/wb_sram_byte_en_ctrl.sv
// Wishbone classic-cycle slave in front of a byte-enable SRAM macro with one-cycle read latency.
// Registers each request, issues a single SRAM access, and answers with ack (or err when out of range).
module wb_sram_byte_en_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10,
    parameter int WB_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_in0,
    input  logic                       scan_in1,
    input  logic                       scan_in2,
    input  logic                       scan_in3,
    input  logic                       scan_in4,
    input  logic                       scan_enable,
    input  logic                       test_mode,
    output logic                       scan_out0,
    output logic                       scan_out1,
    output logic                       scan_out2,
    output logic                       scan_out3,
    output logic                       scan_out4,
    input  logic [WB_ADDR_WIDTH-1:0]   i_wb_adr,
    input  logic [DATA_WIDTH/8-1:0]    i_wb_sel,
    input  logic                       i_wb_we,
    input  logic [DATA_WIDTH-1:0]      i_wb_dat,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    output logic [DATA_WIDTH-1:0]      o_wb_dat,
    output logic                       o_wb_ack,
    output logic                       o_wb_err,
    output logic [ADDRESS_WIDTH-1:0]   o_sram_address,
    output logic [DATA_WIDTH-1:0]      o_sram_write_data,
    output logic                       o_sram_write_enable,
    output logic [DATA_WIDTH/8-1:0]    o_sram_byte_enable,
    input  logic [DATA_WIDTH-1:0]      i_sram_read_data,
    output logic                       o_busy
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    // state  | meaning
    // IDLE   | waiting for cyc&stb; request registered into the SRAM output stage
    // ACCESS | SRAM address/byte enables (and write strobe) driven for one cycle
    // RDWAIT | macro read data valid; captured into the bus read register
    // RESP   | one-cycle ack or err back to the master
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                   state_q;
    logic                     we_q;
    logic                     ack_q;
    logic                     err_q;
    logic                     sram_we_q;
    logic [ADDRESS_WIDTH-1:0] sram_addr_q;
    logic [DATA_WIDTH-1:0]    sram_wdata_q;
    logic [SEL_WIDTH-1:0]     sram_be_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic                     req;
    logic                     out_of_range;
    logic [ADDRESS_WIDTH-1:0] word_adr;
    logic                     unused_inputs;

    assign req          = i_wb_cyc & i_wb_stb;
    assign word_adr     = i_wb_adr[ADDRESS_WIDTH+1:2];
    assign out_of_range = |i_wb_adr[WB_ADDR_WIDTH-1:ADDRESS_WIDTH+2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_be_q    <= '0;
            rdata_q      <= '0;
        end else begin
            // SRAM stage and responses are single-cycle pulses unless re-armed below
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_be_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (out_of_range) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            we_q         <= i_wb_we;
                            sram_we_q    <= i_wb_we;
                            sram_addr_q  <= word_adr;
                            sram_be_q    <= i_wb_sel;
                            sram_wdata_q <= i_wb_we ? i_wb_dat : '0;
                            state_q      <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!i_wb_cyc) begin
                        state_q <= IDLE;
                    end else if (we_q) begin
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (!i_wb_cyc) begin
                        state_q <= IDLE;
                    end else begin
                        rdata_q <= i_sram_read_data;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A master that drops cyc while the response is up has abandoned the cycle.
    assign o_wb_ack            = ack_q & i_wb_cyc;
    assign o_wb_err            = err_q & i_wb_cyc;
    assign o_wb_dat            = rdata_q;
    assign o_sram_address      = sram_addr_q;
    assign o_sram_write_data   = sram_wdata_q;
    assign o_sram_write_enable = sram_we_q;
    assign o_sram_byte_enable  = sram_be_q;
    assign o_busy              = (state_q != IDLE);

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    assign unused_inputs = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                             scan_enable, test_mode, i_wb_adr[1:0]};

endmodule

// File: tb/tb_wb_sram_byte_en_ctrl.sv
// Self-checking bench: random Wishbone traffic against a word-array reference memory,
// with a behavioural one-cycle-latency SRAM attached to the design.
module tb_wb_sram_byte_en_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int WAW = 32;
    localparam int SW  = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic          scan_enable, test_mode;
    logic          scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic [WAW-1:0] i_wb_adr;
    logic [SW-1:0] i_wb_sel;
    logic          i_wb_we;
    logic [DW-1:0] i_wb_dat;
    logic          i_wb_cyc, i_wb_stb;
    logic [DW-1:0] o_wb_dat;
    logic          o_wb_ack, o_wb_err;
    logic [AW-1:0] o_sram_address;
    logic [DW-1:0] o_sram_write_data;
    logic          o_sram_write_enable;
    logic [SW-1:0] o_sram_byte_enable;
    logic [DW-1:0] i_sram_read_data;
    logic          o_busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];
    logic [DW-1:0] last_rd;
    logic          clr_mem;

    wb_sram_byte_en_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WB_ADDR_WIDTH(WAW)) dut (
        .clk(clk), .reset(reset),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_sram_address(o_sram_address), .o_sram_write_data(o_sram_write_data),
        .o_sram_write_enable(o_sram_write_enable), .o_sram_byte_enable(o_sram_byte_enable),
        .i_sram_read_data(i_sram_read_data), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // SRAM macro: byte-masked write, read data one clock after the address
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
        end else if (o_sram_write_enable) begin
            for (int b = 0; b < SW; b++)
                if (o_sram_byte_enable[b])
                    sram_mem[o_sram_address][8*b +: 8] <= o_sram_write_data[8*b +: 8];
        end
        i_sram_read_data <= sram_mem[o_sram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_sel = '0;
        i_wb_adr = '0;
        i_wb_dat = '0;
    endtask

    task automatic model_write(input logic [WAW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
        for (int b = 0; b < SW; b++)
            if (s[b]) ref_mem[a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    // One bus transfer. pre = 1 when issued during the previous transfer's response cycle.
    task automatic run_xfer(input logic [WAW-1:0] a, input logic [SW-1:0] s, input logic w,
                            input logic [DW-1:0] d, input int pre, input logic hold,
                            output logic [DW-1:0] rdat);
        logic          oor;
        logic [AW-1:0] word;
        int            lat;
        oor  = (a[WAW-1:AW+2] != '0);
        word = a[AW+1:2];
        lat  = oor ? 1 : (w ? 2 : 3);
        rdat = '0;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        i_wb_adr = a; i_wb_sel = s; i_wb_we = w; i_wb_dat = d;
        for (int c = 1; c <= pre + lat; c++) begin
            tick();
            vectors++;
            if (c == pre + 1 && !oor) begin
                if (o_sram_address !== word || o_sram_byte_enable !== s ||
                    o_sram_write_enable !== w || (w && o_sram_write_data !== d)) begin
                    miscompares++;
                    $display("FAIL sram_access adr=%h: got addr=%h be=%h we=%b wd=%h, want addr=%h be=%h we=%b wd=%h",
                             a, o_sram_address, o_sram_byte_enable, o_sram_write_enable,
                             o_sram_write_data, word, s, w, d);
                end
            end else if (o_sram_address !== '0 || o_sram_byte_enable !== '0 ||
                         o_sram_write_enable !== 1'b0 || o_sram_write_data !== '0) begin
                miscompares++;
                $display("FAIL sram_quiet adr=%h cycle %0d: got addr=%h be=%h we=%b wd=%h, want all 0",
                         a, c, o_sram_address, o_sram_byte_enable, o_sram_write_enable, o_sram_write_data);
            end
            vectors++;
            if (o_busy !== (c > pre)) begin
                miscompares++;
                $display("FAIL busy adr=%h cycle %0d: got %b want %b", a, c, o_busy, (c > pre));
            end
            vectors++;
            if (c < pre + lat) begin
                if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_resp adr=%h cycle %0d: got ack=%b err=%b want 0/0",
                             a, c, o_wb_ack, o_wb_err);
                end
            end else begin
                if (o_wb_ack !== !oor || o_wb_err !== oor) begin
                    miscompares++;
                    $display("FAIL resp adr=%h cycle %0d: got ack=%b err=%b want ack=%b err=%b",
                             a, c, o_wb_ack, o_wb_err, !oor, oor);
                end
                vectors++;
                rdat = o_wb_dat;
                if (!oor && !w) begin
                    if (o_wb_dat !== ref_mem[word]) begin
                        miscompares++;
                        $display("FAIL rdata adr=%h: got %h want %h", a, o_wb_dat, ref_mem[word]);
                    end
                end else if (o_wb_dat !== last_rd) begin
                    miscompares++;
                    $display("FAIL rdata_hold adr=%h: got %h want %h", a, o_wb_dat, last_rd);
                end
            end
        end
        if (!oor && w) model_write(a, s, d);
        if (!oor && !w) last_rd = ref_mem[word];
        if (!hold) begin
            idle_bus();
            tick();
            vectors++;
            if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0 || o_busy !== 1'b0 ||
                o_sram_write_enable !== 1'b0 || o_wb_dat !== last_rd) begin
                miscompares++;
                $display("FAIL after_resp adr=%h: got ack=%b err=%b busy=%b we=%b dat=%h want 0/0/0/0 dat=%h",
                         a, o_wb_ack, o_wb_err, o_busy, o_sram_write_enable, o_wb_dat, last_rd);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr_mem = 1'b1;
        scan_in0 = 1'b0; scan_in1 = 1'b1; scan_in2 = 1'b0; scan_in3 = 1'b1; scan_in4 = 1'b0;
        scan_enable = 1'b0; test_mode = 1'b0;
        idle_bus();
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        last_rd = '0;
        tick();
        tick();
        clr_mem = 1'b0;
        vectors++;
        if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0 || o_busy !== 1'b0 || o_wb_dat !== '0 ||
            o_sram_address !== '0 || o_sram_write_data !== '0 || o_sram_write_enable !== 1'b0 ||
            o_sram_byte_enable !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ack=%b err=%b busy=%b dat=%h addr=%h wd=%h we=%b be=%h want all 0",
                     o_wb_ack, o_wb_err, o_busy, o_wb_dat, o_sram_address, o_sram_write_data,
                     o_sram_write_enable, o_sram_byte_enable);
        end
        vectors++;
        if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
            miscompares++;
            $display("FAIL scan_out: got %b want 00000",
                     {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (o_busy !== 1'b0 || o_wb_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got busy=%b ack=%b want 0/0", o_busy, o_wb_ack);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] r;
        run_xfer(32'h10, 4'hF, 1'b1, 32'hDEADBEEF, 0, 1'b0, r);
        run_xfer(32'h10, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        vectors++;
        if (r !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL readback_full: got %h want deadbeef", r);
        end
        run_xfer(32'h10, 4'h2, 1'b1, 32'h0000AA00, 0, 1'b0, r);
        run_xfer(32'h13, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        vectors++;
        if (r !== 32'hDEADAAEF) begin
            miscompares++;
            $display("FAIL readback_byte: got %h want deadaaef", r);
        end
        run_xfer(32'h0000_1000, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        run_xfer(32'h8000_0010, 4'hF, 1'b1, 32'h12345678, 0, 1'b0, r);
        run_xfer(32'h0000_0FFC, 4'hF, 1'b1, 32'hCAFEF00D, 0, 1'b0, r);
        run_xfer(32'h0000_0FFC, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        run_xfer(32'h14, 4'h0, 1'b1, 32'hFFFFFFFF, 0, 1'b0, r);
        run_xfer(32'h14, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL sel_zero_write: got %h want 00000000", r);
        end
    endtask

    task automatic rand_xfer(output logic [WAW-1:0] a, output logic [SW-1:0] s,
                             output logic w, output logic [DW-1:0] d);
        a = WAW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[WAW-1:AW+2] = 20'($urandom_range(1, 20'hFFFFF));
        s = SW'($urandom_range(0, 15));
        w = 1'($urandom_range(0, 1));
        d = $urandom();
    endtask

    task automatic test_random();
        logic [WAW-1:0] a;
        logic [SW-1:0]  s;
        logic           w, hold;
        logic [DW-1:0]  d, r;
        int             pre;
        pre = 0;
        for (int i = 0; i < 60; i++) begin
            rand_xfer(a, s, w, d);
            hold = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
            run_xfer(a, s, w, d, pre, hold, r);
            pre = hold ? 1 : 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [WAW-1:0] a;
        logic [SW-1:0]  s;
        logic           w;
        logic [DW-1:0]  d, r;
        for (int i = 0; i < 8; i++) begin
            rand_xfer(a, s, w, d);
            run_xfer(a, s, w, d, (i == 0) ? 0 : 1, (i != 7), r);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] r, d;
        // read dropped in RDWAIT
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_adr = 32'h10;
        tick();
        tick();
        idle_bus();
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0 || o_busy !== 1'b0 || o_wb_dat !== last_rd) begin
                miscompares++;
                $display("FAIL abort_rdwait cycle %0d: got ack=%b err=%b busy=%b dat=%h want 0/0/0 dat=%h",
                         c, o_wb_ack, o_wb_err, o_busy, o_wb_dat, last_rd);
            end
        end
        d = $urandom();
        run_xfer(32'h24, 4'hF, 1'b1, d, 0, 1'b0, r);
        run_xfer(32'h24, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        // write dropped in ACCESS is still committed
        d = $urandom();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_sel = 4'h5; i_wb_adr = 32'h28; i_wb_dat = d;
        tick();
        vectors++;
        if (o_sram_write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_access_we: got %b want 1", o_sram_write_enable);
        end
        idle_bus();
        model_write(32'h28, 4'h5, d);
        tick();
        vectors++;
        if (o_wb_ack !== 1'b0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_access: got ack=%b busy=%b want 0/0", o_wb_ack, o_busy);
        end
        run_xfer(32'h28, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
        // cyc dropped while ack is up
        d = $urandom();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_sel = 4'hF; i_wb_adr = 32'h2C; i_wb_dat = d;
        tick();
        tick();
        idle_bus();
        model_write(32'h2C, 4'hF, d);
        #1;
        vectors++;
        if (o_wb_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_resp: got ack=%b want 0", o_wb_ack);
        end
        tick();
        run_xfer(32'h2C, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] r;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_sel = 4'hF;
        i_wb_adr = 32'h30; i_wb_dat = 32'h5A5A_1234;
        tick();
        vectors++;
        if (o_sram_write_enable !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got we=%b busy=%b want 1/1", o_sram_write_enable, o_busy);
        end
        #1 reset = 1'b1;
        #1;
        last_rd = '0;
        vectors++;
        if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0 || o_busy !== 1'b0 || o_wb_dat !== '0 ||
            o_sram_address !== '0 || o_sram_write_data !== '0 || o_sram_write_enable !== 1'b0 ||
            o_sram_byte_enable !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got ack=%b err=%b busy=%b dat=%h addr=%h wd=%h we=%b be=%h want all 0",
                     o_wb_ack, o_wb_err, o_busy, o_wb_dat, o_sram_address, o_sram_write_data,
                     o_sram_write_enable, o_sram_byte_enable);
        end
        idle_bus();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (o_wb_ack !== 1'b0 || o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_after cycle %0d: got ack=%b busy=%b want 0/0", c, o_wb_ack, o_busy);
            end
        end
        run_xfer(32'h30, 4'hF, 1'b0, 32'h0, 0, 1'b0, r);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_sram_byte_en_ctrl.md
Name: wb_sram_byte_en_ctrl

Overview:
Wishbone classic-cycle slave that fronts the byte-enable SRAM macro and sits directly upstream of it. It registers each bus request, issues one SRAM access with per-byte enables, captures read data after the macro's one-cycle read latency, and returns ack or err. It carries the standard scan port set so DFT insertion treats it like every other block.

Parameters:
DATA_WIDTH, 32, bus and SRAM data width; must be a multiple of 8
ADDRESS_WIDTH, 10, SRAM word-address width (depth = 2**ADDRESS_WIDTH words)
WB_ADDR_WIDTH, 32, Wishbone byte-address width

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
scan_in0..scan_in4  in  1 each  scan chain inputs
scan_enable  in  1  scan shift enable
test_mode  in  1  DFT test mode
scan_out0..scan_out4  out  1 each  scan chain outputs
i_wb_adr  in  WB_ADDR_WIDTH  byte address
i_wb_sel  in  DATA_WIDTH/8  byte selects
i_wb_we  in  1  1 = write
i_wb_dat  in  DATA_WIDTH  write data
i_wb_cyc  in  1  cycle valid
i_wb_stb  in  1  strobe
o_wb_dat  out  DATA_WIDTH  read data
o_wb_ack  out  1  transfer done
o_wb_err  out  1  address out of range
o_sram_address  out  ADDRESS_WIDTH  SRAM word address
o_sram_write_data  out  DATA_WIDTH  SRAM write data
o_sram_write_enable  out  1  SRAM write strobe
o_sram_byte_enable  out  DATA_WIDTH/8  SRAM byte enables
i_sram_read_data  in  DATA_WIDTH  SRAM read data, valid one clk after address
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0. scan_out* = 0 in RTL; DFT stitches the chains. scan_enable and test_mode have no functional effect.
- Word address = i_wb_adr[ADDRESS_WIDTH+1:2]. Low two bits are ignored.
- A request is out of range when any bit i_wb_adr[WB_ADDR_WIDTH-1:ADDRESS_WIDTH+2] is nonzero.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - On cyc&stb, register adr, we, sel, dat and go to ACCESS.
  - An out-of-range request goes directly to RESP with err set.
- ACCESS:
  - Drive o_sram_address and o_sram_byte_enable = registered sel for exactly one cycle.
  - Write: o_sram_write_enable = 1 and o_sram_write_data = registered dat for that cycle; go to RESP.
  - Read: write_enable = 0; go to RDWAIT.
- RDWAIT: latch i_sram_read_data into o_wb_dat; go to RESP.
- RESP:
  - o_wb_ack (or o_wb_err) = 1 for exactly one cycle; go to IDLE.
  - o_wb_dat holds its value until the next read completes.
- Latency from request seen in IDLE: write ack at +2 cycles, read ack at +3 cycles, err at +1 cycle.
- ack and err are never high together and never high for two consecutive cycles.
- SRAM outputs are 0 outside ACCESS; o_sram_write_enable is never high outside ACCESS.
- Back-to-back: if cyc&stb is still high in IDLE after RESP, it is a new request (master-pipelined usage).
- Abort: i_wb_cyc low in ACCESS, RDWAIT or RESP suppresses ack/err and returns the FSM to IDLE the next cycle. A write already issued in ACCESS is not undone.
- sel = 0 on a write: the access is still issued with byte_enable 0, and ack is returned.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no ack is produced for the interrupted request.

Test Plan:
- After reset, write adr 0x10, sel 0xF, dat 0xDEADBEEF -> one-cycle write_enable with sram address 4, byte_enable 0xF; ack at +2.
- Read back adr 0x10 with the SRAM model returning 0xDEADBEEF -> o_wb_dat = 0xDEADBEEF; ack at +3, err = 0.
- Write adr 0x10, sel 0x2, dat 0x0000AA00 -> byte_enable 0x2; a subsequent read returns 0xDEADAAEF.
- Read adr 0x0000_1000 (beyond 1K words) -> err at +1; no SRAM strobe or address activity; ack = 0.
- Drop cyc during RDWAIT -> no ack; FSM in IDLE next cycle; a following write completes normally.
- Assert reset during ACCESS of a write -> all outputs 0 immediately; o_busy = 0; no ack after reset is released.
